// File: rtl/fpu_align_seq.sv
// fpu_align_seq: multi-cycle exponent alignment for the FPU add/sub path.
// Shifts the smaller-exponent mantissa right by up to STEP bits per cycle, accumulating sticky.
module fpu_align_seq #(
  parameter int MANT_W = 64,
  parameter int EXP_W  = 16,
  parameter int STEP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [MANT_W-1:0] a_num,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [MANT_W-1:0] b_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_a_num,
  output logic [MANT_W-1:0] out_b_num,
  output logic              out_swap,
  output logic              inexact,
  output logic              busy
);
  localparam int RW = $clog2(MANT_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state;
  logic [RW-1:0]     rem, remInit, stepAmt;
  logic [EXP_W-1:0]  expDiff;
  logic [MANT_W-1:0] cur;
  logic              aGe, lost;
  always_comb begin
    aGe     = a_exp >= b_exp;
    expDiff = aGe ? a_exp - b_exp : b_exp - a_exp;
    remInit = 32'(expDiff) >= MANT_W ? RW'(MANT_W) : RW'(expDiff);
    stepAmt = 32'(rem) < STEP ? rem : RW'(STEP);
    cur     = out_swap ? out_a_num : out_b_num;
    // stepAmt==MANT_W makes the mask all ones, so the whole mantissa feeds sticky
    lost    = |(cur & ~({MANT_W{1'b1}} << stepAmt));
  end
  assign in_ready  = state == IDLE && !flush;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      out_exp   <= '0;
      out_a_num <= '0;
      out_b_num <= '0;
      out_swap  <= 1'b0;
      inexact   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (state == IDLE && in_valid) begin
      out_exp   <= aGe ? a_exp : b_exp;
      out_a_num <= a_num;
      out_b_num <= b_num;
      out_swap  <= !aGe;
      inexact   <= 1'b0;
      rem       <= remInit;
      state     <= remInit == '0 ? DONE : SHIFT;
    end else if (state == SHIFT) begin
      if (out_swap) out_a_num <= cur >> stepAmt;
      else out_b_num <= cur >> stepAmt;
      inexact <= inexact | lost;
      rem     <= rem - stepAmt;
      state   <= rem == stepAmt ? DONE : SHIFT;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fpu_align_seq.sv
// tb_fpu_align_seq: table vectors, corner sequences and random pairs checked
// against a wide-arithmetic reference of the alignment.
module tb_fpu_align_seq;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] a_exp = 0, b_exp = 0;
  logic [63:0] a_num = 0, b_num = 0;
  logic        in_ready, out_valid, out_swap, inexact, busy;
  logic [15:0] out_exp;
  logic [63:0] out_a_num, out_b_num;
  int nVec = 0, nMis = 0;

  fpu_align_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .a_num(a_num), .b_exp(b_exp), .b_num(b_num),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_a_num(out_a_num), .out_b_num(out_b_num), .out_swap(out_swap),
    .inexact(inexact), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ae; logic [63:0] an; logic [15:0] be; logic [63:0] bn;
    logic [15:0] xe; logic [63:0] xa; logic [63:0] xb; logic xs; logic xi; int xl;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: place the shifted mantissa above 64 zero bits; what slides below is the lost part.
  function automatic vec_t refAlign(input logic [15:0] ae, input logic [63:0] an,
                                    input logic [15:0] be, input logic [63:0] bn);
    vec_t v;
    int d;
    logic [127:0] w;
    logic sw;
    sw = be > ae;
    d = sw ? int'(be) - int'(ae) : int'(ae) - int'(be);
    if (d > 64) d = 64;
    w = {sw ? an : bn, 64'h0} >> d;
    v.ae = ae; v.an = an; v.be = be; v.bn = bn;
    v.xe = sw ? be : ae;
    v.xa = sw ? w[127:64] : an;
    v.xb = sw ? bn : w[127:64];
    v.xs = sw;
    v.xi = |w[63:0];
    v.xl = d == 0 ? 1 : 1 + (d + 7) / 8;
    return v;
  endfunction

  task automatic apply(input logic [15:0] ae, input logic [63:0] an,
                       input logic [15:0] be, input logic [63:0] bn);
    a_exp = ae; a_num = an; b_exp = be; b_num = bn; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_after_hs", busy, 0);
  endtask

  task automatic runVec(input string nm, input vec_t v, input int hold);
    int lat;
    apply(v.ae, v.an, v.be, v.bn);
    waitValid(lat);
    chk({nm, "_lat"}, lat, v.xl);
    repeat (hold) begin @(posedge clk); #1; end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_exp"}, out_exp, v.xe);
    chk({nm, "_a"}, out_a_num, v.xa);
    chk({nm, "_b"}, out_b_num, v.xb);
    chk({nm, "_swap"}, out_swap, v.xs);
    chk({nm, "_inexact"}, inexact, v.xi);
    handshake();
  endtask

  task automatic neverValid(input string nm);
    int hits = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) hits++; end
    chk(nm, hits, 0);
  endtask

  initial begin
    vec_t tbl[8];
    logic [15:0] sExp;
    logic [63:0] sA, sB;
    logic sI;
    int lat;
    tbl[0] = '{16'd100, 64'h8000_0000_0000_0000, 16'd100, 64'h1,
               16'd100, 64'h8000_0000_0000_0000, 64'h1, 0, 0, 1};
    tbl[1] = '{16'd100, 64'h4000_0000_0000_0000, 16'd95, 64'h21,
               16'd100, 64'h4000_0000_0000_0000, 64'h1, 0, 1, 2};
    tbl[2] = '{16'd80, 64'h0010_0000_0000_0000, 16'd100, 64'h1234,
               16'd100, 64'h0000_0001_0000_0000, 64'h1234, 1, 0, 4};
    tbl[3] = '{16'd300, 64'h5, 16'd100, 64'hFFFF_FFFF_FFFF_FFFF,
               16'd300, 64'h5, 64'h0, 0, 1, 9};
    tbl[4] = '{16'd300, 64'h5, 16'd100, 64'h0,
               16'd300, 64'h5, 64'h0, 0, 0, 9};
    tbl[5] = '{16'd10, 64'hFF, 16'd18, 64'h77,
               16'd18, 64'h0, 64'h77, 1, 1, 2};
    tbl[6] = '{16'd64, 64'h9, 16'd0, 64'h8000_0000_0000_0001,
               16'd64, 64'h9, 64'h0, 0, 1, 9};
    tbl[7] = '{16'd7, 64'hF00, 16'd15, 64'h3,
               16'd15, 64'hF, 64'h3, 1, 0, 2};

    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exp", out_exp, 0);
    chk("rst_a", out_a_num, 0);
    chk("rst_b", out_b_num, 0);
    chk("rst_inexact", inexact, 0);
    @(posedge clk); #1;
    rst = 0; #1;
    chk("rst_in_ready", in_ready, 1);

    foreach (tbl[i]) runVec($sformatf("tbl%0d", i), tbl[i], 0);

    // backpressure: outputs frozen and no capture while DONE waits
    apply(16'd100, 64'h4000_0000_0000_0000, 16'd95, 64'h21);
    waitValid(lat);
    chk("bp_lat", lat, 2);
    sExp = out_exp; sA = out_a_num; sB = out_b_num; sI = inexact;
    a_exp = 16'd3; a_num = 64'hDEAD; b_exp = 16'd900; b_num = 64'hBEEF; in_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_exp", out_exp, sExp);
      chk("bp_a", out_a_num, sA);
      chk("bp_b", out_b_num, sB);
      chk("bp_inexact", inexact, sI);
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    chk("bp_idle", busy, 0);
    chk("bp_nocap_b", out_b_num, sB);

    // flush beats in_valid in IDLE
    flush = 1; in_valid = 1; #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_nocap", busy, 0);

    // flush on the second SHIFT cycle of a diff=40 op
    apply(16'd140, 64'h1234_5678_9ABC_DEF0, 16'd100, 64'hFFFF_0000_FFFF_0000);
    chk("fl_busy", busy, 1);
    @(posedge clk); #1;
    chk("fl_busy2", busy, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("fl_idle", busy, 0);
    neverValid("fl_no_valid");

    // flush together with out_ready in DONE
    apply(16'd5, 64'h1, 16'd5, 64'h2);
    chk("fld_valid", out_valid, 1);
    flush = 1; out_ready = 1;
    @(posedge clk); #1;
    flush = 0; out_ready = 0;
    chk("fld_idle", busy, 0);

    // asynchronous reset mid-SHIFT
    apply(16'd140, 64'h1234_5678_9ABC_DEF0, 16'd100, 64'hFFFF_0000_FFFF_0000);
    @(posedge clk); #3;
    rst = 1; #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_exp", out_exp, 0);
    chk("ar_a", out_a_num, 0);
    chk("ar_b", out_b_num, 0);
    chk("ar_swap", out_swap, 0);
    chk("ar_inexact", inexact, 0);
    @(posedge clk); #1;
    rst = 0; #1;
    chk("ar_in_ready", in_ready, 1);
    neverValid("ar_no_valid");

    // random pairs against the reference
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ae, be;
      logic [63:0] an, bn;
      ae = 16'($urandom_range(0, 200));
      be = (i % 4 == 0) ? ae : 16'($urandom_range(0, 200));
      an = {$urandom, $urandom} >> $urandom_range(0, 63);
      bn = {$urandom, $urandom} << $urandom_range(0, 63);
      runVec($sformatf("rnd%0d", i), refAlign(ae, an, be, bn), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
